alt_vipitc120_video_out_timing: RTL and testbench

- Read-side consumer of the clocked-video output FIFO: pops pixels and generates the panel timing stream (DE, HSYNC, VSYNC, data) for the MTL2 800x480 display.
- The FIFO is non-showahead: q is valid one cycle after rdreq.
- The FIFO word MSB is a start-of-frame (SOF) flag; the remaining bits are pixel data.
- Handles frame alignment, underflow and resynchronisation, all in the read clock domain.

---
 rtl/alt_vipitc120_video_out_timing.sv | 212 +++++++++++++++++++++
 tb/tb_alt_vipitc120_video_out_timing.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipitc120_video_out_timing.sv
// Clocked-video output timing generator for the MTL2 800x480 panel.
// Pops pixels from a non-showahead FIFO and drives DE/HSYNC/VSYNC/data.
//
// Ports (all in the rdclk domain):
//   rdclk, aclr_n       clock, asynchronous active-low reset
//   enable              allow a new frame to start at the frame boundary
//   rdempty, rdusedw, q FIFO status and read data (q valid one cycle after rdreq)
//   rdreq               FIFO pop
//   vid_data, vid_de    pixel data and data enable
//   vid_hsync/vsync     active-low syncs
//   running             output stage is streaming a frame
//   underflow           sticky underflow / SOF-misalignment flag
//   clear_underflow     clears underflow (a new event wins)
module alt_vipitc120_video_out_timing #(
    parameter int DATA_WIDTH  = 20,
    parameter int DATA_WIDTHU = 11,
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 210,
    parameter int H_SYNC      = 30,
    parameter int H_BP        = 16,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 22,
    parameter int V_SYNC      = 13,
    parameter int V_BP        = 10,
    parameter int FILL_LEVEL  = 1024
) (
    input  logic                    rdclk,
    input  logic                    aclr_n,
    input  logic                    enable,
    input  logic                    rdempty,
    input  logic [DATA_WIDTHU-1:0]  rdusedw,
    input  logic [DATA_WIDTH-1:0]   q,
    output logic                    rdreq,
    output logic [DATA_WIDTH-2:0]   vid_data,
    output logic                    vid_de,
    output logic                    vid_hsync,
    output logic                    vid_vsync,
    output logic                    running,
    output logic                    underflow,
    input  logic                    clear_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_WAIT_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic            held_valid_q, held_valid_d;
    logic [PW-1:0]   held_data_q, held_data_d;
    logic            underflow_q, underflow_d;

    // First pipeline stage: position flags plus how the pixel was sourced.
    logic            s1_active_q, s1_hs_q, s1_vs_q;
    logic            s1_rd_q, s1_src_q, s1_held_q, s1_first_q;

    // Second pipeline stage: the pins.
    logic [PW-1:0]   vid_data_q, vid_data_d;
    logic            vid_de_q, vid_hsync_q, vid_vsync_q;

    logic            h_last, v_last, frame_end, first;
    logic            active, hs, vs;
    logic            src, held_sel, uf_set;
    logic            sof_in, sof_err;
    logic [PW-1:0]   pix_in;

    always_comb begin
        h_last    = (h_cnt_q == HW'(H_TOTAL - 1));
        v_last    = (v_cnt_q == VW'(V_TOTAL - 1));
        frame_end = h_last && v_last;
        first     = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end

        active = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
        hs     = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                 (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
        vs     = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                 (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
    end

    // The word sourced last cycle is now visible; the held word is always a SOF.
    always_comb begin
        sof_in  = s1_held_q ? 1'b1 : q[DATA_WIDTH-1];
        pix_in  = s1_held_q ? held_data_q : q[PW-1:0];
        sof_err = s1_src_q && (sof_in != s1_first_q);
    end

    always_comb begin
        state_d      = state_q;
        rdreq        = 1'b0;
        src          = 1'b0;
        held_sel     = 1'b0;
        uf_set       = 1'b0;
        held_valid_d = held_valid_q;
        held_data_d  = held_data_q;

        unique case (state_q)
            S_WAIT_FILL: begin
                if (frame_end && enable &&
                    (held_valid_q || rdusedw >= DATA_WIDTHU'(FILL_LEVEL))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A misaligned word stops further reads this cycle so that
                // the flush sees every word still in the FIFO.
                if (sof_err) begin
                    uf_set  = 1'b1;
                    state_d = S_FLUSH;
                end else if (active) begin
                    if (first && held_valid_q) begin
                        src          = 1'b1;
                        held_sel     = 1'b1;
                        held_valid_d = 1'b0;
                    end else if (!rdempty) begin
                        rdreq = 1'b1;
                        src   = 1'b1;
                    end else begin
                        uf_set  = 1'b1;
                        state_d = S_FLUSH;
                    end
                end else if (frame_end && !enable) begin
                    state_d = S_WAIT_FILL;
                end
            end
            S_FLUSH: begin
                // One read in flight at a time so each word gets inspected.
                rdreq = !rdempty && !s1_rd_q;
                if (s1_rd_q && q[DATA_WIDTH-1]) begin
                    held_data_d  = q[PW-1:0];
                    held_valid_d = 1'b1;
                    state_d      = S_WAIT_FILL;
                end
            end
            default: begin
                state_d = S_WAIT_FILL;
            end
        endcase

        if (uf_set) begin
            underflow_d = 1'b1;
        end else if (clear_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end

        vid_data_d = s1_src_q ? pix_in : '0;
    end

    always_ff @(posedge rdclk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q      <= S_WAIT_FILL;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            held_valid_q <= 1'b0;
            held_data_q  <= '0;
            underflow_q  <= 1'b0;
            s1_active_q  <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s1_rd_q      <= 1'b0;
            s1_src_q     <= 1'b0;
            s1_held_q    <= 1'b0;
            s1_first_q   <= 1'b0;
            vid_data_q   <= '0;
            vid_de_q     <= 1'b0;
            vid_hsync_q  <= 1'b1;
            vid_vsync_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            held_valid_q <= held_valid_d;
            held_data_q  <= held_data_d;
            underflow_q  <= underflow_d;
            s1_active_q  <= active;
            s1_hs_q      <= hs;
            s1_vs_q      <= vs;
            s1_rd_q      <= rdreq;
            s1_src_q     <= src;
            s1_held_q    <= held_sel;
            s1_first_q   <= first;
            vid_data_q   <= vid_data_d;
            vid_de_q     <= s1_active_q;
            vid_hsync_q  <= ~s1_hs_q;
            vid_vsync_q  <= ~s1_vs_q;
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_de    = vid_de_q;
    assign vid_hsync = vid_hsync_q;
    assign vid_vsync = vid_vsync_q;
    assign running   = (state_q == S_RUN);
    assign underflow = underflow_q;

endmodule

// File: tb/tb_alt_vipitc120_video_out_timing.sv
// Randomized bench for the video output timing block on a 7x5 raster.
// A FIFO model feeds the DUT; a frame-level reference predicts every pin.
module tb_alt_vipitc120_video_out_timing;

    localparam int DW   = 20;
    localparam int PW   = 19;
    localparam int HA   = 4;
    localparam int HF   = 1;
    localparam int HS   = 1;
    localparam int HB   = 1;
    localparam int VA   = 2;
    localparam int VF   = 1;
    localparam int VS   = 1;
    localparam int VB   = 1;
    localparam int FILL = 4;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int FT   = HT * VT;
    localparam int NPIX = HA * VA;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          enable = 1'b0;
    logic          rdempty = 1'b1;
    logic [10:0]   rdusedw = '0;
    logic [DW-1:0] q = '0;
    logic          clear_underflow = 1'b0;
    logic          rdreq;
    logic [PW-1:0] vid_data;
    logic          vid_de, vid_hsync, vid_vsync, running, underflow;

    always #5 clk = ~clk;

    alt_vipitc120_video_out_timing #(
        .DATA_WIDTH(DW), .DATA_WIDTHU(11),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FILL_LEVEL(FILL)
    ) dut (
        .rdclk(clk), .aclr_n(aclr_n), .enable(enable),
        .rdempty(rdempty), .rdusedw(rdusedw), .q(q),
        .rdreq(rdreq), .vid_data(vid_data), .vid_de(vid_de),
        .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .running(running), .underflow(underflow),
        .clear_underflow(clear_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // FIFO contents and the frame-structured word stream feeding it.
    logic [DW-1:0] fifo[$];
    int            spos = 0;

    task automatic push_word(input int corrupt_pct);
        logic [DW-1:0] w;
        w = DW'($urandom);
        w[DW-1] = (spos == 0);
        if ($urandom_range(0, 99) < corrupt_pct) w[DW-1] = ~w[DW-1];
        spos = (spos + 1) % NPIX;
        fifo.push_back(w);
    endtask

    // Reference: mode 0 = waiting for fill, 1 = running, 2 = flushing.
    int            m_cnt, m_mode;
    bit            m_held_v, m_err_pend, m_fsof_pend, m_rd_prev, m_uf;
    logic [PW-1:0] m_held_d, m_fsof_d;
    bit            p_de[2], p_hs[2], p_vs[2];
    logic [PW-1:0] p_dat[2];

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_held_v = 0; m_err_pend = 0;
        m_fsof_pend = 0; m_rd_prev = 0; m_uf = 0;
        m_held_d = '0; m_fsof_d = '0;
        for (int i = 0; i < 2; i++) begin
            p_de[i] = 0; p_hs[i] = 0; p_vs[i] = 0; p_dat[i] = '0;
        end
    endtask

    task automatic step_model(output bit rd);
        int            h, v, nmode;
        bit            act, hsr, vsr, first, last, uf_set, nerr, nf;
        logic [DW-1:0] w;
        logic [PW-1:0] dat, fd;
        h = m_cnt % HT;
        v = m_cnt / HT;
        act   = (h < HA) && (v < VA);
        hsr   = (h >= HA + HF) && (h < HA + HF + HS);
        vsr   = (v >= VA + VF) && (v < VA + VF + VS);
        first = (m_cnt == 0);
        last  = (m_cnt == FT - 1);

        check("de", vid_de, p_de[1]);
        check("hsync", vid_hsync, !p_hs[1]);
        check("vsync", vid_vsync, !p_vs[1]);
        check("data", vid_data, p_dat[1]);
        check("running", running, m_mode == 1);
        check("underflow", underflow, m_uf);

        rd = 0; dat = '0; nmode = m_mode; uf_set = 0; nerr = 0; nf = 0; fd = '0;
        case (m_mode)
            0: begin
                if (last && enable && (m_held_v || fifo.size() >= FILL)) nmode = 1;
            end
            1: begin
                if (m_err_pend) begin
                    uf_set = 1; nmode = 2;
                end else if (act) begin
                    if (first && m_held_v) begin
                        dat = m_held_d; m_held_v = 0;
                    end else if (fifo.size() > 0) begin
                        rd = 1; w = fifo[0]; dat = w[PW-1:0];
                        nerr = (w[DW-1] != first);
                    end else begin
                        uf_set = 1; nmode = 2;
                    end
                end else if (last && !enable) begin
                    nmode = 0;
                end
            end
            default: begin
                if (m_fsof_pend) begin
                    m_held_v = 1; m_held_d = m_fsof_d; nmode = 0;
                end else if (fifo.size() > 0 && !m_rd_prev) begin
                    rd = 1; w = fifo[0];
                    if (w[DW-1]) begin nf = 1; fd = w[PW-1:0]; end
                end
            end
        endcase

        check("rdreq", rdreq, rd);
        check("rdreq_empty", rdreq && rdempty, 0);

        m_uf = uf_set ? 1'b1 : (clear_underflow ? 1'b0 : m_uf);
        m_mode = nmode;
        m_err_pend = nerr;
        m_fsof_pend = nf;
        m_fsof_d = fd;
        m_rd_prev = rd;
        p_de[1] = p_de[0]; p_hs[1] = p_hs[0]; p_vs[1] = p_vs[0]; p_dat[1] = p_dat[0];
        p_de[0] = act; p_hs[0] = hsr; p_vs[0] = vsr; p_dat[0] = dat;
        m_cnt = (m_cnt + 1) % FT;
    endtask

    task automatic run_cycles(input int n, input int push_pct, input int en_pct,
                              input int clr_pct, input int corrupt_pct);
        bit rd_exp, dut_rd;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 99) < en_pct);
            clear_underflow = ($urandom_range(0, 99) < clr_pct);
            if (fifo.size() < 40 && $urandom_range(0, 99) < push_pct) push_word(corrupt_pct);
            rdempty = (fifo.size() == 0);
            rdusedw = 11'(fifo.size());
            #1;
            step_model(rd_exp);
            dut_rd = rdreq;
            @(posedge clk);
            #1;
            if (dut_rd && fifo.size() > 0) q = fifo.pop_front();
        end
    endtask

    task automatic check_reset_values();
        check("rst_rdreq", rdreq, 0);
        check("rst_data", vid_data, 0);
        check("rst_de", vid_de, 0);
        check("rst_hsync", vid_hsync, 1);
        check("rst_vsync", vid_vsync, 1);
        check("rst_running", running, 0);
        check("rst_underflow", underflow, 0);
    endtask

    initial begin
        model_reset();
        aclr_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 aclr_n = 1'b1;

        run_cycles(70, 0, 0, 0, 0);
        run_cycles(400, 30, 100, 0, 0);
        run_cycles(500, 18, 95, 3, 0);
        run_cycles(500, 28, 95, 5, 10);
        run_cycles(400, 25, 60, 10, 3);

        @(negedge clk);
        #2 aclr_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1 aclr_n = 1'b1;
        run_cycles(300, 30, 100, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
